// File: rtl/spc_debug_unit.sv
// spc_debug_unit: SPC700 breakpoint / watchpoint / single-step controller on the host debug register bus.
// Latency: BRK_OUT rises on the edge sampling a qualifying EN cycle; register reads are combinational.
// Backpressure: none on the host bus; the CPU is stalled through BRK_OUT until the host re-arms RUN.
// Optional feature macro: SPC_DBG_WATCH_EN enables data read/write watchpoints.
module spc_debug_unit #(
   parameter int         NUM_BP   = 4,
   parameter logic [7:0] REG_BASE = 8'h80
) (
   input  logic        CLK,
   input  logic        RST_N,
   input  logic        EN,
   input  logic        LAST_CYCLE,
   input  logic [15:0] NEXT_PC,
   input  logic [15:0] A_OUT,
   input  logic        WE_N,
   input  logic [7:0]  DBG_REG,
   input  logic [7:0]  DBG_DAT_IN,
   input  logic        DBG_DAT_WR,
   output logic [7:0]  DBG_DAT_OUT,
   output logic        BRK_OUT,
   output logic [3:0]  HIT_IDX
);

   typedef enum logic {ST_RUN = 1'b0, ST_HALTED = 1'b1} state_t;

   typedef struct packed {
      logic [15:0] addr;
      logic [3:0]  mode;     // {enable, write, read, exec}
      logic [7:0]  hit_cnt;
   } bp_t;

`ifdef SPC_DBG_WATCH_EN
   localparam logic [3:0] MODE_MASK = 4'b1111;
`else
   // Without watchpoints the read/write mode bits are never stored.
   localparam logic [3:0] MODE_MASK = 4'b1001;
   logic unused_watch;
   assign unused_watch = ^{A_OUT, WE_N};
`endif

   localparam logic [7:0] CTRL_ADDR = REG_BASE + 8'(4 * NUM_BP);
   localparam logic [7:0] STAT_ADDR = CTRL_ADDR + 8'd1;

   bp_t         bp_q [NUM_BP];
   logic [7:0]  ctrl_q;
   logic        wr_r;
   state_t      state_q, state_nxt;
   logic        brk_q, brk_nxt;
   logic [3:0]  hit_idx_q, hit_idx_nxt;
   logic        step_halt_q, step_halt_nxt;

   logic              wr_commit;
   logic              ctrl_wr;
   logic              resume;
   logic [NUM_BP-1:0] bp_match;
   logic              any_match;
   logic              step_match;
   logic [3:0]        first_idx;

   // A held DBG_DAT_WR commits only on its first cycle.
   assign wr_commit  = DBG_DAT_WR & ~wr_r;
   assign ctrl_wr    = wr_commit && (DBG_REG == CTRL_ADDR);
   assign resume     = ctrl_wr && DBG_DAT_IN[7] && !ctrl_q[7];
   assign any_match  = |bp_match;
   assign step_match = (state_q == ST_RUN) && ctrl_q[0] && LAST_CYCLE && EN;

   // Per-comparator match, only while running and the CPU advances.
   always_comb begin
      bp_match = '0;
      for (int i = 0; i < NUM_BP; i++) begin
         if (state_q == ST_RUN && EN && bp_q[i].mode[3]) begin
            if (bp_q[i].mode[0] && LAST_CYCLE && NEXT_PC == bp_q[i].addr)
               bp_match[i] = 1'b1;
`ifdef SPC_DBG_WATCH_EN
            if (bp_q[i].mode[1] && WE_N && A_OUT == bp_q[i].addr)
               bp_match[i] = 1'b1;
            if (bp_q[i].mode[2] && !WE_N && A_OUT == bp_q[i].addr)
               bp_match[i] = 1'b1;
`endif
         end
      end
   end

   // Lowest matching index wins; scan downward so the last assignment is the lowest.
   always_comb begin
      first_idx = 4'hF;
      for (int i = NUM_BP - 1; i >= 0; i--) begin
         if (bp_match[i])
            first_idx = 4'(i);
      end
   end

   // Run/halt next-state and latched halt information.
   always_comb begin
      state_nxt     = state_q;
      brk_nxt       = brk_q;
      hit_idx_nxt   = hit_idx_q;
      step_halt_nxt = step_halt_q;
      case (state_q)
         ST_RUN: begin
            if (any_match || step_match) begin
               state_nxt     = ST_HALTED;
               brk_nxt       = 1'b1;
               hit_idx_nxt   = first_idx;
               step_halt_nxt = ~any_match;
            end
         end
         ST_HALTED: begin
            if (resume) begin
               state_nxt = ST_RUN;
               brk_nxt   = 1'b0;
            end
         end
         default: state_nxt = ST_RUN;
      endcase
   end

   // FSM state and halt status registers.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         state_q     <= ST_RUN;
         brk_q       <= 1'b0;
         hit_idx_q   <= 4'hF;
         step_halt_q <= 1'b0;
      end else begin
         state_q     <= state_nxt;
         brk_q       <= brk_nxt;
         hit_idx_q   <= hit_idx_nxt;
         step_halt_q <= step_halt_nxt;
      end
   end

   // Host-writable registers and saturating hit counters; a clear coinciding with a hit yields 1.
   always_ff @(posedge CLK) begin
      if (!RST_N) begin
         wr_r   <= 1'b0;
         ctrl_q <= 8'h00;
         for (int i = 0; i < NUM_BP; i++)
            bp_q[i] <= '0;
      end else begin
         wr_r <= DBG_DAT_WR;
         if (ctrl_wr)
            ctrl_q <= DBG_DAT_IN;
         for (int i = 0; i < NUM_BP; i++) begin
            if (wr_commit && DBG_REG == REG_BASE + 8'(4 * i))
               bp_q[i].addr[7:0] <= DBG_DAT_IN;
            if (wr_commit && DBG_REG == REG_BASE + 8'(4 * i + 1))
               bp_q[i].addr[15:8] <= DBG_DAT_IN;
            if (wr_commit && DBG_REG == REG_BASE + 8'(4 * i + 2))
               bp_q[i].mode <= DBG_DAT_IN[3:0] & MODE_MASK;
            if (wr_commit && DBG_REG == REG_BASE + 8'(4 * i + 3))
               bp_q[i].hit_cnt <= bp_match[i] ? 8'd1 : 8'd0;
            else if (bp_match[i] && bp_q[i].hit_cnt != 8'hFF)
               bp_q[i].hit_cnt <= bp_q[i].hit_cnt + 8'd1;
         end
      end
   end

   // Combinational register read mux; unmapped addresses read zero.
   always_comb begin
      DBG_DAT_OUT = 8'h00;
      for (int i = 0; i < NUM_BP; i++) begin
         if (DBG_REG == REG_BASE + 8'(4 * i))
            DBG_DAT_OUT = bp_q[i].addr[7:0];
         if (DBG_REG == REG_BASE + 8'(4 * i + 1))
            DBG_DAT_OUT = bp_q[i].addr[15:8];
         if (DBG_REG == REG_BASE + 8'(4 * i + 2))
            DBG_DAT_OUT = {4'h0, bp_q[i].mode};
         if (DBG_REG == REG_BASE + 8'(4 * i + 3))
            DBG_DAT_OUT = bp_q[i].hit_cnt;
      end
      if (DBG_REG == CTRL_ADDR)
         DBG_DAT_OUT = ctrl_q;
      if (DBG_REG == STAT_ADDR)
         DBG_DAT_OUT = {state_q == ST_HALTED, step_halt_q, 2'b00, hit_idx_q};
   end

   assign BRK_OUT = brk_q;
   assign HIT_IDX = hit_idx_q;

endmodule

// File: tb/tb_spc_debug_unit.sv
// tb_spc_debug_unit: self-checking bench for spc_debug_unit (NUM_BP=4, REG_BASE=8'h80).
// Expected register readbacks are queued as each scenario drives stimulus, then drained and compared.
// Outputs are sampled on the falling edge or #1 after a register select change.
module tb_spc_debug_unit;

   localparam int         NUM_BP   = 4;
   localparam logic [7:0] REG_BASE = 8'h80;
   localparam logic [7:0] CTRL_A   = 8'h90;
   localparam logic [7:0] STAT_A   = 8'h91;

   logic        CLK = 1'b0;
   logic        RST_N;
   logic        EN;
   logic        LAST_CYCLE;
   logic [15:0] NEXT_PC;
   logic [15:0] A_OUT;
   logic        WE_N;
   logic [7:0]  DBG_REG;
   logic [7:0]  DBG_DAT_IN;
   logic        DBG_DAT_WR;
   logic [7:0]  DBG_DAT_OUT;
   logic        BRK_OUT;
   logic [3:0]  HIT_IDX;

   int checks = 0;
   int errors = 0;

   typedef struct {
      string      name;
      logic [7:0] addr;
      logic [7:0] val;
   } rd_exp_t;

   rd_exp_t sb_q[$];

   spc_debug_unit #(.NUM_BP(NUM_BP), .REG_BASE(REG_BASE)) dut (
      .CLK(CLK), .RST_N(RST_N), .EN(EN), .LAST_CYCLE(LAST_CYCLE),
      .NEXT_PC(NEXT_PC), .A_OUT(A_OUT), .WE_N(WE_N),
      .DBG_REG(DBG_REG), .DBG_DAT_IN(DBG_DAT_IN), .DBG_DAT_WR(DBG_DAT_WR),
      .DBG_DAT_OUT(DBG_DAT_OUT), .BRK_OUT(BRK_OUT), .HIT_IDX(HIT_IDX)
   );

   always #5 CLK = ~CLK;

   initial begin
      #1_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic expect_reg(input string name, input logic [7:0] addr, input logic [7:0] val);
      rd_exp_t e;
      e.name = name;
      e.addr = addr;
      e.val  = val;
      sb_q.push_back(e);
   endtask

   task automatic host_write(input logic [7:0] addr, input logic [7:0] data);
      @(negedge CLK);
      DBG_REG    = addr;
      DBG_DAT_IN = data;
      DBG_DAT_WR = 1'b1;
      @(negedge CLK);
      DBG_DAT_WR = 1'b0;
   endtask

   task automatic cpu_pulse(input logic en, input logic last, input logic [15:0] pc,
                            input logic [15:0] a, input logic wen);
      @(negedge CLK);
      EN = en; LAST_CYCLE = last; NEXT_PC = pc; A_OUT = a; WE_N = wen;
      @(negedge CLK);
      EN = 1'b0; LAST_CYCLE = 1'b0; NEXT_PC = 16'h0000; A_OUT = 16'h0000; WE_N = 1'b1;
   endtask

   task automatic do_resume();
      host_write(CTRL_A, 8'h00);
      host_write(CTRL_A, 8'h80);
   endtask

   task automatic test_reset();
      rd_exp_t e;
      RST_N = 1'b0; EN = 1'b0; LAST_CYCLE = 1'b0; NEXT_PC = 16'h0; A_OUT = 16'h0;
      WE_N = 1'b1; DBG_REG = 8'h00; DBG_DAT_IN = 8'h00; DBG_DAT_WR = 1'b0;
      repeat (3) @(negedge CLK);
      RST_N = 1'b1;
      @(negedge CLK);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL reset brk: got %b exp 0", BRK_OUT); end
      checks++;
      if (HIT_IDX !== 4'hF) begin errors++; $display("FAIL reset hit_idx: got %h exp f", HIT_IDX); end
      for (int i = 0; i < 4 * NUM_BP + 1; i++)
         expect_reg("reset reg", REG_BASE + 8'(i), 8'h00);
      expect_reg("reset status", STAT_A, 8'h0F);
      expect_reg("reset unmapped", 8'h10, 8'h00);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
   endtask

   task automatic test_exec();
      rd_exp_t e;
      host_write(8'h80, 8'h34);
      host_write(8'h81, 8'h12);
      host_write(8'h82, 8'h09);
      cpu_pulse(1'b0, 1'b1, 16'h1234, 16'h0, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL exec en0 brk: got %b exp 0", BRK_OUT); end
      cpu_pulse(1'b1, 1'b1, 16'h1234, 16'h0, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b1) begin errors++; $display("FAIL exec brk: got %b exp 1", BRK_OUT); end
      checks++;
      if (HIT_IDX !== 4'h0) begin errors++; $display("FAIL exec hit_idx: got %h exp 0", HIT_IDX); end
      expect_reg("exec addr lo", 8'h80, 8'h34);
      expect_reg("exec addr hi", 8'h81, 8'h12);
      expect_reg("exec mode", 8'h82, 8'h09);
      expect_reg("exec status", STAT_A, 8'h80);
      expect_reg("exec hitcnt0", 8'h83, 8'h01);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
   endtask

   task automatic test_resume();
      rd_exp_t e;
      host_write(CTRL_A, 8'h80);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL resume brk: got %b exp 0", BRK_OUT); end
      // Hold the write strobe for 5 cycles while moving the select: only the first cycle commits.
      @(negedge CLK);
      DBG_REG = 8'h80; DBG_DAT_IN = 8'h55; DBG_DAT_WR = 1'b1;
      @(negedge CLK);
      DBG_REG = 8'h84; DBG_DAT_IN = 8'h66;
      repeat (4) @(negedge CLK);
      DBG_DAT_WR = 1'b0;
      @(negedge CLK);
      expect_reg("resume ctrl", CTRL_A, 8'h80);
      expect_reg("resume status", STAT_A, 8'h00);
      expect_reg("hold first commit", 8'h80, 8'h55);
      expect_reg("hold no repeat", 8'h84, 8'h00);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
   endtask

   task automatic test_priority();
      rd_exp_t e;
      host_write(8'h84, 8'h00);
      host_write(8'h85, 8'h04);
      host_write(8'h86, 8'h09);
      host_write(8'h88, 8'h00);
      host_write(8'h89, 8'h04);
      host_write(8'h8A, 8'hF9);
      cpu_pulse(1'b1, 1'b1, 16'h0400, 16'h0, 1'b1);
      checks++;
      if (HIT_IDX !== 4'h1) begin errors++; $display("FAIL prio hit_idx: got %h exp 1", HIT_IDX); end
      expect_reg("prio mode2 upper bits", 8'h8A, 8'h09);
      expect_reg("prio status", STAT_A, 8'h81);
      expect_reg("prio hitcnt0", 8'h83, 8'h01);
      expect_reg("prio hitcnt1", 8'h87, 8'h01);
      expect_reg("prio hitcnt2", 8'h8B, 8'h01);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
      do_resume();
      for (int k = 0; k < 300; k++) begin
         cpu_pulse(1'b1, 1'b1, 16'h0400, 16'h0, 1'b1);
         do_resume();
      end
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL sat brk: got %b exp 0", BRK_OUT); end
      expect_reg("sat hitcnt1", 8'h87, 8'hFF);
      expect_reg("sat hitcnt2", 8'h8B, 8'hFF);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
      // Clear of HITCNT1 in the same cycle as a hit on comparator 1.
      @(negedge CLK);
      DBG_REG = 8'h87; DBG_DAT_IN = 8'h00; DBG_DAT_WR = 1'b1;
      EN = 1'b1; LAST_CYCLE = 1'b1; NEXT_PC = 16'h0400;
      @(negedge CLK);
      DBG_DAT_WR = 1'b0; EN = 1'b0; LAST_CYCLE = 1'b0; NEXT_PC = 16'h0000;
      checks++;
      if (BRK_OUT !== 1'b1) begin errors++; $display("FAIL clr+hit brk: got %b exp 1", BRK_OUT); end
      expect_reg("clr+hit hitcnt1", 8'h87, 8'h01);
      expect_reg("clr+hit hitcnt2", 8'h8B, 8'hFF);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
      do_resume();
   endtask

   task automatic test_step();
      rd_exp_t e;
      host_write(CTRL_A, 8'h3D);
      host_write(CTRL_A, 8'hBD);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL step run-in-run brk: got %b exp 0", BRK_OUT); end
      cpu_pulse(1'b0, 1'b1, 16'h2000, 16'h0, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL step en0 brk: got %b exp 0", BRK_OUT); end
      cpu_pulse(1'b1, 1'b1, 16'h2000, 16'h0, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b1) begin errors++; $display("FAIL step brk: got %b exp 1", BRK_OUT); end
      checks++;
      if (HIT_IDX !== 4'hF) begin errors++; $display("FAIL step hit_idx: got %h exp f", HIT_IDX); end
      expect_reg("step ctrl", CTRL_A, 8'hBD);
      expect_reg("step status", STAT_A, 8'hCF);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
      do_resume();
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL step resume brk: got %b exp 0", BRK_OUT); end
   endtask

   task automatic test_watch();
      rd_exp_t e;
      host_write(8'h8C, 8'hF2);
      host_write(8'h8D, 8'h00);
`ifdef SPC_DBG_WATCH_EN
      host_write(8'h8E, 8'h0C);
      cpu_pulse(1'b1, 1'b0, 16'h0, 16'h00F2, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL watch read brk: got %b exp 0", BRK_OUT); end
      cpu_pulse(1'b1, 1'b0, 16'h0, 16'h00F2, 1'b0);
      checks++;
      if (BRK_OUT !== 1'b1) begin errors++; $display("FAIL watch write brk: got %b exp 1", BRK_OUT); end
      checks++;
      if (HIT_IDX !== 4'h3) begin errors++; $display("FAIL watch hit_idx: got %h exp 3", HIT_IDX); end
      expect_reg("watch mode3", 8'h8E, 8'h0C);
      expect_reg("watch status", STAT_A, 8'h83);
      expect_reg("watch hitcnt3", 8'h8F, 8'h01);
`else
      host_write(8'h8E, 8'h0E);
      cpu_pulse(1'b1, 1'b0, 16'h0, 16'h00F2, 1'b0);
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL nowatch brk: got %b exp 0", BRK_OUT); end
      expect_reg("nowatch mode3", 8'h8E, 8'h08);
      expect_reg("nowatch hitcnt3", 8'h8F, 8'h00);
`endif
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
      do_resume();
   endtask

   task automatic test_reset_mid_halt();
      rd_exp_t e;
      host_write(8'h80, 8'h34);
      cpu_pulse(1'b1, 1'b1, 16'h1234, 16'h0, 1'b1);
      checks++;
      if (BRK_OUT !== 1'b1) begin errors++; $display("FAIL pre-reset brk: got %b exp 1", BRK_OUT); end
      @(negedge CLK);
      RST_N = 1'b0;
      @(negedge CLK);
      RST_N = 1'b1;
      checks++;
      if (BRK_OUT !== 1'b0) begin errors++; $display("FAIL midhalt brk: got %b exp 0", BRK_OUT); end
      checks++;
      if (HIT_IDX !== 4'hF) begin errors++; $display("FAIL midhalt hit_idx: got %h exp f", HIT_IDX); end
      for (int i = 0; i < 4 * NUM_BP + 1; i++)
         expect_reg("midhalt reg", REG_BASE + 8'(i), 8'h00);
      // Status carries HIT_IDX in its low nibble, which resets to F.
      expect_reg("midhalt status", STAT_A, 8'h0F);
      while (sb_q.size() > 0) begin
         e = sb_q.pop_front();
         DBG_REG = e.addr; #1;
         checks++;
         if (DBG_DAT_OUT !== e.val) begin
            errors++;
            $display("FAIL %s @%02h: got %02h exp %02h", e.name, e.addr, DBG_DAT_OUT, e.val);
         end
      end
   endtask

   initial begin
      test_reset();
      test_exec();
      test_resume();
      test_priority();
      test_step();
      test_watch();
      test_reset_mid_halt();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
